// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reverse reorder block.
// Holds the bank-select encoding, the read-FSM state encoding and the bitrev helper.
package fft_bitrev_reorder_pkg;

    localparam int MAX_STAGES = 16;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverses the low 'width' bits of val; bits above width come back as zero.
    function automatic logic [MAX_STAGES-1:0] bitrev(input logic [MAX_STAGES-1:0] val,
                                                     input int                    width);
        logic [MAX_STAGES-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < width) r[i] = val[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_sdp_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port; array contents are not reset.
// Read latency 1; the read register holds while rd_vld_i is low and clears on reset or clr_i.
module fft_bitrev_reorder_sdp_ram #(
    parameter int AW = 4,
    parameter int DW = 36
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          clr_i,
    input  logic          wr_vld_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_vld_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_dat_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (wr_vld_i) mem[wr_addr_i] <= wr_dat_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_dat_q <= '0;
        end else if (clr_i) begin
            rd_dat_q <= '0;
        end else if (rd_vld_i) begin
            rd_dat_q <= mem[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed DIF FFT output frames into natural order through a ping-pong frame RAM.
// First output 2 cycles after a frame's last input, then N gapless cycles; no backpressure, drops flagged by o_ovf_strb.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int TOTAL_STAGES = 8,
    parameter int IN_W         = 18,
    parameter int RAM_LAT      = 1
) (
    input  logic                    mclk,
    input  logic                    i_init_n,
    input  logic                    i_init,
    input  logic                    i_vld,
    input  logic signed [IN_W-1:0]  i_I,
    input  logic signed [IN_W-1:0]  i_Q,
    output logic                    o_vld,
    output logic signed [IN_W-1:0]  o_I,
    output logic signed [IN_W-1:0]  o_Q,
    output logic                    o_sof,
    output logic [TOTAL_STAGES-1:0] o_idx,
    output logic                    o_ovf_strb
);

    localparam int                    FFT_N = 2**TOTAL_STAGES;
    localparam int                    AW    = TOTAL_STAGES + 1;
    localparam int                    DW    = 2 * IN_W;
    localparam logic [TOTAL_STAGES-1:0] LAST = TOTAL_STAGES'(FFT_N - 1);

    if (RAM_LAT != 1) begin : g_bad_ram_lat
        $error("fft_bitrev_reorder supports RAM_LAT == 1 only");
    end

    rd_state_e               state_q, state_d;
    bank_e                   wbank_q, wbank_d, rbank_q, rbank_d;
    bank_e                   wbank_other, rbank_other;
    logic [1:0]              full_q, full_d;
    logic [TOTAL_STAGES-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [TOTAL_STAGES-1:0] idx_q;
    logic                    vld_q, sof_q, ovf_q, ovf_d;
    logic                    rd_en, rd_last, rel_wbank, wr_en;
    logic [AW-1:0]           wr_addr, rd_addr;
    logic [DW-1:0]           rd_dat;

    assign wbank_other = bank_e'(~wbank_q);
    assign rbank_other = bank_e'(~rbank_q);
    assign rd_en       = (state_q == RD_READ);
    assign rd_last     = rd_en && (rcnt_q == LAST);
    // The bank finishing its read this cycle may already take bin 0 of the next frame.
    assign rel_wbank   = rd_last && (rbank_q == wbank_q);
    assign wr_en       = i_vld && !i_init && (!full_q[wbank_q] || rel_wbank);
    assign ovf_d       = i_vld && full_q[wbank_q] && !rel_wbank;
    assign wr_addr     = {wbank_q, TOTAL_STAGES'(bitrev(MAX_STAGES'(wcnt_q), TOTAL_STAGES))};
    assign rd_addr     = {rbank_q, rcnt_q};

    always_comb begin
        state_d = state_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        full_d  = full_q;

        if (rd_last) full_d[rbank_q] = 1'b0;
        if (wr_en) begin
            wcnt_d = wcnt_q + TOTAL_STAGES'(1);
            if (wcnt_q == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = wbank_other;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (|full_q) begin
                    state_d = RD_READ;
                    rbank_d = full_q[wbank_other] ? wbank_other : wbank_q;
                    rcnt_d  = '0;
                end
            end
            RD_READ: begin
                rcnt_d = rcnt_q + TOTAL_STAGES'(1);
                if (rd_last) begin
                    if (full_q[rbank_other]) rbank_d = rbank_other;
                    else                     state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge i_init_n) begin
        if (!i_init_n) begin
            state_q <= RD_IDLE;
            wbank_q <= BANK_0;
            rbank_q <= BANK_0;
            full_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (i_init) begin
            state_q <= RD_IDLE;
            wbank_q <= BANK_0;
            rbank_q <= BANK_0;
            full_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            vld_q   <= rd_en;
            sof_q   <= rd_en && (rcnt_q == '0);
            ovf_q   <= ovf_d;
            if (rd_en) idx_q <= rcnt_q;
        end
    end

    // The RAM read register doubles as the o_I/o_Q output register.
    fft_bitrev_reorder_sdp_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i     (mclk),
        .arst_ni   (i_init_n),
        .clr_i     (i_init),
        .wr_vld_i  (wr_en),
        .wr_addr_i (wr_addr),
        .wr_dat_i  ({i_I, i_Q}),
        .rd_vld_i  (rd_en),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (rd_dat)
    );

    assign o_vld      = vld_q;
    assign o_sof      = sof_q;
    assign o_idx      = idx_q;
    assign o_ovf_strb = ovf_q;
    assign o_I        = rd_dat[DW-1:IN_W];
    assign o_Q        = rd_dat[IN_W-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder at N=8: table-driven frames plus hand sequences for flush and async reset.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    localparam int TS = 3;
    localparam int N  = 8;
    localparam int W  = 18;

    logic                 mclk = 1'b0;
    logic                 i_init_n, i_init, i_vld;
    logic signed [W-1:0]  i_I, i_Q;
    logic                 o_vld, o_sof, o_ovf_strb;
    logic signed [W-1:0]  o_I, o_Q;
    logic [TS-1:0]        o_idx;

    always #5 mclk = ~mclk;

    fft_bitrev_reorder #(
        .TOTAL_STAGES (TS),
        .IN_W         (W),
        .RAM_LAT      (1)
    ) dut (
        .mclk       (mclk),
        .i_init_n   (i_init_n),
        .i_init     (i_init),
        .i_vld      (i_vld),
        .i_I        (i_I),
        .i_Q        (i_Q),
        .o_vld      (o_vld),
        .o_I        (o_I),
        .o_Q        (o_Q),
        .o_sof      (o_sof),
        .o_idx      (o_idx),
        .o_ovf_strb (o_ovf_strb)
    );

    typedef struct packed {
        logic [W-1:0]  i;
        logic [W-1:0]  q;
        logic [TS-1:0] idx;
        logic          sof;
    } exp_t;

    typedef struct {
        logic [N-1:0][W-1:0] in_i;
        logic [N-1:0][W-1:0] in_q;
        logic [N-1:0][W-1:0] ex_i;
        logic [N-1:0][W-1:0] ex_q;
        int                  gap;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tv[4];
    vec_t v3f;

    int ramp_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int desc_exp[8] = '{7, 3, 5, 1, 6, 2, 4, 0};

    int errors = 0, checks = 0;
    int cyc = 0, last_in_cyc = 0, rise_cyc = 0, run = 0, last_run = 0, resid = 0;
    bit prev_vld = 1'b0, ovf_seen = 1'b0, found = 1'b0;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every o_vld and tracks burst shape.
    always @(negedge mclk) begin
        if (o_ovf_strb === 1'b1) ovf_seen = 1'b1;
        if (o_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: o_idx=%0d o_I=%0h with no output pending", o_idx, o_I);
            end else begin
                mon_e = sbq.pop_front();
                chk("o_I", 64'($unsigned(o_I)), 64'(mon_e.i));
                chk("o_Q", 64'($unsigned(o_Q)), 64'(mon_e.q));
                chk("o_idx", 64'(o_idx), 64'(mon_e.idx));
                chk("o_sof", 64'(o_sof), 64'(mon_e.sof));
                if (mon_e.idx != 0) chk("in_frame_bubble", 64'(prev_vld), 64'(1));
            end
            if (!prev_vld) rise_cyc = cyc;
            run++;
        end else begin
            if (prev_vld) last_run = run;
            run = 0;
        end
        prev_vld = (o_vld === 1'b1);
    end

    task automatic push_exp(input vec_t v);
        for (int b = 0; b < N; b++)
            sbq.push_back('{i: v.ex_i[b], q: v.ex_q[b], idx: TS'(b), sof: (b == 0)});
    endtask

    task automatic send_frame(input logic [N-1:0][W-1:0] fi, input logic [N-1:0][W-1:0] fq,
                              input int gap, input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge mclk);
            i_vld       = 1'b1;
            i_I         = fi[k];
            i_Q         = fq[k];
            last_in_cyc = cyc + 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge mclk);
                i_vld = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sbq.size() != 0 && t < budget) begin
            @(negedge mclk);
            t++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outputs still pending, required 0", sbq.size());
            sbq.delete();
        end
        repeat (3) @(negedge mclk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            tv[0].in_i[k] = W'(k);
            tv[0].in_q[k] = W'(50 + k);
            tv[0].ex_i[k] = W'(ramp_exp[k]);
            tv[0].ex_q[k] = W'(50 + ramp_exp[k]);
            tv[2].in_i[k] = (k == 1) ? 18'h1FFFF : '0;
            tv[2].in_q[k] = (k == 1) ? '1 : '0;
            tv[2].ex_i[k] = (k == 4) ? 18'h1FFFF : '0;
            tv[2].ex_q[k] = (k == 4) ? '1 : '0;
            tv[3].in_i[k] = W'(7 - k);
            tv[3].in_q[k] = W'(100 + k);
            tv[3].ex_i[k] = W'(desc_exp[k]);
            tv[3].ex_q[k] = W'(100 + ramp_exp[k]);
        end
        tv[0].gap = 0;
        tv[1]     = tv[0];
        tv[1].gap = 2;
        tv[2].gap = 0;
        tv[3].gap = 1;

        i_init_n = 1'b0;
        i_init   = 1'b0;
        i_vld    = 1'b0;
        i_I      = '0;
        i_Q      = '0;
        repeat (3) @(negedge mclk);
        chk("rst_o_vld", 64'(o_vld), 64'(0));
        chk("rst_o_sof", 64'(o_sof), 64'(0));
        chk("rst_o_ovf", 64'(o_ovf_strb), 64'(0));
        chk("rst_o_idx", 64'(o_idx), 64'(0));
        chk("rst_o_I", 64'($unsigned(o_I)), 64'(0));
        chk("rst_o_Q", 64'($unsigned(o_Q)), 64'(0));
        i_init_n = 1'b1;
        repeat (2) @(negedge mclk);

        // Isolated frames: ramp, gapped ramp, impulse, descending.
        for (int e = 0; e < 4; e++) begin
            push_exp(tv[e]);
            send_frame(tv[e].in_i, tv[e].in_q, tv[e].gap, N);
            @(negedge mclk);
            i_vld = 1'b0;
            wait_drain(200);
            chk("first_out_latency", 64'(rise_cyc - last_in_cyc), 64'(2));
            chk("burst_len", 64'(last_run), 64'(N));
        end

        // Three back-to-back frames with continuous input.
        for (int f = 0; f < 3; f++) begin
            v3f = tv[0];
            for (int k = 0; k < N; k++) begin
                v3f.in_i[k] = W'(k + 8 * f);
                v3f.ex_i[k] = W'(ramp_exp[k] + 8 * f);
            end
            push_exp(v3f);
            send_frame(v3f.in_i, v3f.in_q, 0, N);
        end
        @(negedge mclk);
        i_vld = 1'b0;
        wait_drain(300);
        chk("b2b_burst_len", 64'(last_run), 64'(3 * N));

        // Flush after 5 samples, then a clean ramp.
        send_frame(tv[3].in_i, tv[3].in_q, 0, 5);
        @(negedge mclk);
        i_vld  = 1'b0;
        i_init = 1'b1;
        @(negedge mclk);
        i_init = 1'b0;
        chk("flush_o_idx", 64'(o_idx), 64'(0));
        chk("flush_o_I", 64'($unsigned(o_I)), 64'(0));
        chk("flush_o_vld", 64'(o_vld), 64'(0));
        push_exp(tv[0]);
        send_frame(tv[0].in_i, tv[0].in_q, 0, N);
        @(negedge mclk);
        i_vld = 1'b0;
        wait_drain(200);
        chk("flush_latency", 64'(rise_cyc - last_in_cyc), 64'(2));

        // Async reset in the middle of a read.
        push_exp(tv[0]);
        send_frame(tv[0].in_i, tv[0].in_q, 0, N);
        @(negedge mclk);
        i_vld = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge mclk);
            if (o_vld === 1'b1 && o_idx == 3) found = 1'b1;
        end
        chk("reach_bin3", 64'(found), 64'(1));
        #2;
        i_init_n = 1'b0;
        #1;
        chk("async_o_vld", 64'(o_vld), 64'(0));
        sbq.delete();
        repeat (2) @(negedge mclk);
        i_init_n = 1'b1;
        resid = 0;
        repeat (20) begin
            @(negedge mclk);
            if (o_vld !== 1'b0) resid++;
        end
        chk("no_residual_out", 64'(resid), 64'(0));
        push_exp(tv[3]);
        send_frame(tv[3].in_i, tv[3].in_q, tv[3].gap, N);
        @(negedge mclk);
        i_vld = 1'b0;
        wait_drain(200);
        chk("post_rst_latency", 64'(rise_cyc - last_in_cyc), 64'(2));

        chk("ovf_never", 64'(ovf_seen), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
